// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg -- shared definitions for the multi-cycle sequencer.
//   state_t          : 3-bit sequencer state encoding
//   ADDR_PC/ADDR_ALU : mem_addr_sel encodings (fetch address vs data address)
//   DEFAULT_WAIT_MAX : default memory-wait budget before faulting
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam int DEFAULT_WAIT_MAX = 16;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if -- bundle between the sequencer and the decoder, datapath,
// register file and memory port.
//   Decoder flags : data_read_en, data_write_en, reg_write_en
//   Memory port   : mem_req, mem_addr_sel, mem_we, mem_ack
//   Strobes       : ir_load, mdr_load, reg_write, pc_write
//   Control       : halt_req, halted, fault
//   Perf counters : cycle_count, retire_count (CNT_W bits)
// Modport master is the sequencer side; slave is the surrounding core.
interface cpu_seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             data_read_en;
  logic             data_write_en;
  logic             reg_write_en;
  logic             mem_ack;
  logic             halt_req;
  logic             mem_req;
  logic             mem_addr_sel;
  logic             mem_we;
  logic             ir_load;
  logic             mdr_load;
  logic             reg_write;
  logic             pc_write;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  modport master (
    input  data_read_en, data_write_en, reg_write_en, mem_ack, halt_req,
    output mem_req, mem_addr_sel, mem_we, ir_load, mdr_load, reg_write,
           pc_write, halted, fault, cycle_count, retire_count
  );

  modport slave (
    output data_read_en, data_write_en, reg_write_en, mem_ack, halt_req,
    input  mem_req, mem_addr_sel, mem_we, ir_load, mdr_load, reg_write,
           pc_write, halted, fault, cycle_count, retire_count
  );

endinterface

// File: rtl/cpu_seq_wait_timer.sv
// cpu_seq_wait_timer -- counts consecutive memory-wait cycles.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : restart the count (sequencer changes state)
//   en         : a request is waiting this cycle without an ack
//   term       : wait budget in cycles (2..255)
//   expired    : this waiting cycle is the last one the budget allows
module cpu_seq_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] term,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 8'd0;
    else if (clr) cnt <= 8'd0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  // cnt holds the number of un-acked cycles already spent, so the
  // term-th waiting cycle sees cnt == term-1.
  assign expired = en && (cnt == term - 8'd1);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl -- multi-cycle instruction sequencer for the 16-bit core.
// Steps FETCH -> DECODE -> EXECUTE -> [MEM] -> WB over one shared memory port,
// with a bounded memory wait (FAULT on timeout) and halt/resume at WB.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cpu_seq_ctrl_if.master (decoder flags, memory handshake,
//                strobes, halt/fault status, performance counters)
//   WAIT_MAX   : cycles a request may wait for mem_ack (2..255)
//   CNT_W      : performance counter width
// Optional feature macro: CPU_SEQ_PERF_EN enables cycle_count/retire_count;
// without it both counters read constant 0.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int WAIT_MAX = DEFAULT_WAIT_MAX,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_seq_ctrl_if.master        bus
);

  state_t state, nxt;
  logic   rd_q, wr_q, rwe_q;
  logic   wait_en, wait_clr, wait_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Decoder flags are only meaningful while IR holds the new instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      rwe_q <= 1'b0;
    end else if (state == ST_DECODE) begin
      rd_q  <= bus.data_read_en;
      wr_q  <= bus.data_write_en;
      rwe_q <= bus.reg_write_en;
    end
  end

  always_comb begin
    nxt              = state;
    bus.mem_req      = 1'b0;
    bus.mem_addr_sel = ADDR_PC;
    bus.mem_we       = 1'b0;
    bus.ir_load      = 1'b0;
    bus.mdr_load     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.pc_write     = 1'b0;
    bus.halted       = 1'b0;
    bus.fault        = 1'b0;
    unique case (state)
      ST_IDLE: nxt = ST_FETCH;
      ST_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_load = 1'b1;
          nxt         = ST_DECODE;
        end else if (wait_expired) begin
          nxt = ST_FAULT;
        end
      end
      ST_DECODE:  nxt = ST_EXECUTE;
      ST_EXECUTE: nxt = (rd_q || wr_q) ? ST_MEM : ST_WB;
      ST_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = ADDR_ALU;
        // A store wins when the decoder flags both directions.
        bus.mem_we       = wr_q;
        if (bus.mem_ack) begin
          bus.mdr_load = rd_q && !wr_q;
          nxt          = ST_WB;
        end else if (wait_expired) begin
          nxt = ST_FAULT;
        end
      end
      ST_WB: begin
        bus.reg_write = rwe_q;
        bus.pc_write  = 1'b1;
        nxt           = bus.halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        bus.halted = 1'b1;
        if (!bus.halt_req) nxt = ST_FETCH;
      end
      ST_FAULT: bus.fault = 1'b1;
      default: nxt = ST_IDLE;
    endcase
  end

  assign wait_en  = ((state == ST_FETCH) || (state == ST_MEM)) && !bus.mem_ack;
  assign wait_clr = (nxt != state);

  cpu_seq_wait_timer u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .term    (8'(WAIT_MAX)),
    .expired (wait_expired)
  );

`ifdef CPU_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if ((state != ST_IDLE) && (state != ST_HALT) && (state != ST_FAULT))
        cyc_q <= cyc_q + 1'b1;
      if (bus.pc_write)
        ret_q <= ret_q + 1'b1;
    end
  end

  assign bus.cycle_count  = cyc_q;
  assign bus.retire_count = ret_q;
`else
  assign bus.cycle_count  = '0;
  assign bus.retire_count = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl -- self-checking bench for cpu_seq_ctrl (WAIT_MAX = 4).
// Each instruction is described by its decoder flags, memory wait counts and
// halt length; from that the bench builds the expected per-cycle output
// schedule together with the inputs to drive, then replays it cycle by cycle.
// Inputs that the sequencer must ignore in a given cycle carry random noise.
module tb_cpu_seq_ctrl;

  localparam int WMAX  = 4;
  localparam int CNT_W = 32;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DEC = 2, PH_EXE = 3,
                 PH_MEM = 4, PH_WB = 5, PH_HALT = 6, PH_FAULT = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_seq_ctrl_if #(.CNT_W(CNT_W)) bus();

  cpu_seq_ctrl #(.WAIT_MAX(WMAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // outv = {mem_req, mem_addr_sel, mem_we, ir_load, mdr_load, reg_write, pc_write, halted, fault}
  typedef struct {
    logic [8:0] outv;
    logic       ack, hreq, rd, wr, rwe;
    logic       active;
    int         ph;
  } step_t;

  step_t sched[$];
  int    exp_cyc = 0;
  int    exp_ret = 0;

  function automatic string ph_name(input int ph);
    case (ph)
      PH_IDLE:  return "idle";
      PH_FETCH: return "fetch";
      PH_DEC:   return "decode";
      PH_EXE:   return "execute";
      PH_MEM:   return "mem";
      PH_WB:    return "wb";
      PH_HALT:  return "halt";
      default:  return "fault";
    endcase
  endfunction

  function automatic logic [8:0] ov(bit req, bit sel, bit we, bit ir, bit mdr,
                                    bit rw, bit pcw, bit hlt, bit flt);
    return {req, sel, we, ir, mdr, rw, pcw, hlt, flt};
  endfunction

  // Step with random decoder flags, ack and halt_req; callers pin what matters.
  function automatic step_t mk(int ph, logic [8:0] o, bit act);
    step_t s;
    s.ph     = ph;
    s.outv   = o;
    s.active = act;
    s.ack    = 1'($urandom);
    s.hreq   = 1'($urandom);
    s.rd     = 1'($urandom);
    s.wr     = 1'($urandom);
    s.rwe    = 1'($urandom);
    return s;
  endfunction

  task automatic add_instr(input bit rd, input bit wr, input bit rwe,
                           input int wf, input int wm, input int hcyc);
    step_t s;
    for (int i = 0; i < wf; i++) begin
      s = mk(PH_FETCH, ov(1,0,0,0,0,0,0,0,0), 1'b1); s.ack = 1'b0; sched.push_back(s);
    end
    s = mk(PH_FETCH, ov(1,0,0,1,0,0,0,0,0), 1'b1); s.ack = 1'b1; sched.push_back(s);
    s = mk(PH_DEC, ov(0,0,0,0,0,0,0,0,0), 1'b1);
    s.rd = rd; s.wr = wr; s.rwe = rwe; sched.push_back(s);
    s = mk(PH_EXE, ov(0,0,0,0,0,0,0,0,0), 1'b1); sched.push_back(s);
    if (rd || wr) begin
      for (int i = 0; i < wm; i++) begin
        s = mk(PH_MEM, ov(1,1,wr,0,0,0,0,0,0), 1'b1); s.ack = 1'b0; sched.push_back(s);
      end
      s = mk(PH_MEM, ov(1,1,wr,0,rd && !wr,0,0,0,0), 1'b1); s.ack = 1'b1; sched.push_back(s);
    end
    s = mk(PH_WB, ov(0,0,0,0,0,rwe,1,0,0), 1'b1); s.hreq = (hcyc > 0); sched.push_back(s);
    for (int h = 0; h < hcyc; h++) begin
      s = mk(PH_HALT, ov(0,0,0,0,0,0,0,1,0), 1'b0); s.hreq = (h < hcyc - 1); sched.push_back(s);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.mem_req, bus.mem_addr_sel, bus.mem_we, bus.ir_load, bus.mdr_load,
            bus.reg_write, bus.pc_write, bus.halted, bus.fault};
  endfunction

  task automatic check_counters(input string tag);
    logic [CNT_W-1:0] ec, er;
`ifdef CPU_SEQ_PERF_EN
    ec = CNT_W'(exp_cyc);
    er = CNT_W'(exp_ret);
`else
    ec = '0;
    er = '0;
`endif
    check({tag, "_cycle_count"}, 64'(bus.cycle_count), 64'(ec));
    check({tag, "_retire_count"}, 64'(bus.retire_count), 64'(er));
  endtask

  // Entered and left at posedge+1; each step is one clock cycle.
  task automatic play();
    step_t s;
    while (sched.size() > 0) begin
      s = sched.pop_front();
      bus.mem_ack       = s.ack;
      bus.halt_req      = s.hreq;
      bus.data_read_en  = s.rd;
      bus.data_write_en = s.wr;
      bus.reg_write_en  = s.rwe;
      @(negedge clk);
      check(ph_name(s.ph), 64'(outs()), 64'(s.outv));
      check_counters(ph_name(s.ph));
      if (s.active) exp_cyc++;
      if (s.outv[2]) exp_ret++;
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset at once, checks the cleared outputs, releases just after
  // an edge and queues the single IDLE cycle that follows release.
  task automatic do_reset();
    step_t s;
    rst_n         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.halt_req  = 1'b1;
    #1;
    exp_cyc = 0;
    exp_ret = 0;
    check("reset_outputs", 64'(outs()), 64'(0));
    check_counters("reset");
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 64'(outs()), 64'(0));
    rst_n = 1'b1;
    s = mk(PH_IDLE, ov(0,0,0,0,0,0,0,0,0), 1'b0);
    sched.push_back(s);
  endtask

  initial begin
    step_t s;
    bus.mem_ack       = 1'b0;
    bus.halt_req      = 1'b0;
    bus.data_read_en  = 1'b0;
    bus.data_write_en = 1'b0;
    bus.reg_write_en  = 1'b0;

    do_reset();
    add_instr(0, 0, 1, 0, 0, 0);   // zero-wait ALU op
    add_instr(0, 1, 0, 0, 3, 0);   // store, data ack delayed 3
    add_instr(1, 0, 1, 0, 0, 0);   // zero-wait load
    add_instr(1, 1, 1, 1, 2, 0);   // both flags: treated as a store
    add_instr(0, 0, 1, 0, 0, 3);   // halt for 3 cycles
    add_instr(1, 0, 1, WMAX-1, WMAX-1, 0);  // ack in the last allowed cycle
    play();

    for (int n = 0; n < 40; n++) begin
      add_instr(1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, WMAX-1)), int'($urandom_range(0, WMAX-1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      play();
    end

    // Fetch never acked: FAULT after WMAX cycles; later acks are ignored.
    for (int i = 0; i < WMAX; i++) begin
      s = mk(PH_FETCH, ov(1,0,0,0,0,0,0,0,0), 1'b1); s.ack = 1'b0; sched.push_back(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = mk(PH_FAULT, ov(0,0,0,0,0,0,0,0,1), 1'b0); s.ack = 1'b1; sched.push_back(s);
    end
    play();
    do_reset();
    add_instr(0, 0, 0, 0, 0, 0);
    play();

    // Reset while a data write is still waiting for its ack.
    s = mk(PH_FETCH, ov(1,0,0,1,0,0,0,0,0), 1'b1); s.ack = 1'b1; sched.push_back(s);
    s = mk(PH_DEC, ov(0,0,0,0,0,0,0,0,0), 1'b1); s.rd = 0; s.wr = 1; s.rwe = 0; sched.push_back(s);
    s = mk(PH_EXE, ov(0,0,0,0,0,0,0,0,0), 1'b1); sched.push_back(s);
    for (int i = 0; i < 2; i++) begin
      s = mk(PH_MEM, ov(1,1,1,0,0,0,0,0,0), 1'b1); s.ack = 1'b0; sched.push_back(s);
    end
    play();
    bus.mem_ack = 1'b0;
    #1;
    check("mid_mem_still_pending", 64'(outs()), 64'(ov(1,1,1,0,0,0,0,0,0)));
    do_reset();
    add_instr(1, 0, 1, 1, 1, 0);
    play();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
